// File: rtl/risky_decode_pkg.sv
// Shared decode definitions: RV32I major opcodes, operation classes and immediate formats.
package risky_decode_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  // CLS_NONE is what an empty DE slot carries.
  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_OP     = 4'd1,
    CLS_OP_IMM = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JAL    = 4'd6,
    CLS_JALR   = 4'd7,
    CLS_LUI    = 4'd8,
    CLS_AUIPC  = 4'd9,
    OP_ILLEGAL = 4'd10
  } op_class_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational RV32I immediate generator: gathers the scattered immediate bits for
// the selected format and sign-extends to 32 bits.
module decode_imm_gen
  import risky_decode_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [2:0]  fmt,
  output logic [31:0] imm
);

  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [20:0] imm_j;

  assign imm_i = inst[31:20];
  assign imm_s = {inst[31:25], inst[11:7]};
  assign imm_b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    imm = '0;
    case (imm_fmt_t'(fmt))
      IMM_I:   imm = 32'(imm_i);
      IMM_S:   imm = 32'(imm_s);
      IMM_B:   imm = 32'(imm_b);
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = 32'(imm_j);
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: RV32I field/immediate decode, in-flight destination scoreboard with
// RAW/overflow hazard back to fetch, and a registered DE bundle to execute.
module decode_stage
  import risky_decode_pkg::*;
#(
  parameter int SB_W = 2,
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] FD_pc,
  input  logic [31:0] FD_inst,
  output logic        is_data_hazard,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        DE_valid,
  output logic [31:0] DE_pc,
  output logic [31:0] DE_inst,
  output logic [4:0]  DE_rs1,
  output logic [4:0]  DE_rs2,
  output logic [4:0]  DE_rd,
  output logic        DE_rd_we,
  output logic [31:0] DE_imm,
  output logic [3:0]  DE_op,
  output logic        sb_err
);

  localparam logic [SB_W-1:0] SB_MAX = '1;

  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  op_class_t   cls;
  imm_fmt_t    fmt;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        has_rd;
  logic        writes_rd;
  logic        bubble;
  logic        issue;
  logic [31:0] imm;

  logic [SB_W-1:0] sb  [NREG];
  logic [SB_W-1:0] eff [NREG];

  assign opcode = FD_inst[6:0];
  assign rd     = FD_inst[11:7];
  assign rs1    = FD_inst[19:15];
  assign rs2    = FD_inst[24:20];
  assign bubble = (FD_inst == 32'd0);

  always_comb begin
    cls      = OP_ILLEGAL;
    fmt      = IMM_NONE;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    has_rd   = 1'b0;
    case (opcode)
      OP:      begin cls = CLS_OP;     uses_rs1 = 1'b1; uses_rs2 = 1'b1; has_rd = 1'b1; end
      OP_IMM:  begin cls = CLS_OP_IMM; fmt = IMM_I; uses_rs1 = 1'b1; has_rd = 1'b1; end
      LOAD:    begin cls = CLS_LOAD;   fmt = IMM_I; uses_rs1 = 1'b1; has_rd = 1'b1; end
      STORE:   begin cls = CLS_STORE;  fmt = IMM_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      BRANCH:  begin cls = CLS_BRANCH; fmt = IMM_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      JAL:     begin cls = CLS_JAL;    fmt = IMM_J; has_rd = 1'b1; end
      JALR:    begin cls = CLS_JALR;   fmt = IMM_I; uses_rs1 = 1'b1; has_rd = 1'b1; end
      LUI:     begin cls = CLS_LUI;    fmt = IMM_U; has_rd = 1'b1; end
      AUIPC:   begin cls = CLS_AUIPC;  fmt = IMM_U; has_rd = 1'b1; end
      default: ;
    endcase
  end

  assign writes_rd = has_rd && (rd != 5'd0);

  decode_imm_gen u_imm (
    .inst (FD_inst),
    .fmt  (fmt),
    .imm  (imm)
  );

  // Same-cycle writeback clears the dependency (write-first regfile); a writer whose
  // counter is already full stalls so the counter can never wrap.
  assign is_data_hazard = !bubble && (
      (uses_rs1 && (rs1 != 5'd0) && (eff[rs1] != '0)) ||
      (uses_rs2 && (rs2 != 5'd0) && (eff[rs2] != '0)) ||
      (writes_rd && (eff[rd] == SB_MAX)));

  assign issue = !bubble && !is_data_hazard;

  assign sb[0]  = '0;
  assign eff[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_sb
    logic [SB_W-1:0] cnt;
    logic            inc;
    logic            dec;

    assign inc = issue && writes_rd && (rd == 5'(r));
    assign dec = wb_valid && (wb_rd == 5'(r)) && (cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
      if (rst)              cnt <= '0;
      else if (inc && !dec) cnt <= cnt + SB_W'(1);
      else if (dec && !inc) cnt <= cnt - SB_W'(1);
    end

    assign sb[r]  = cnt;
    assign eff[r] = cnt - SB_W'(dec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sb_err <= 1'b0;
    else if (wb_valid && (wb_rd != 5'd0) && (sb[wb_rd] == '0))
      sb_err <= 1'b1;
  end

  // FD -> DE boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DE_valid <= 1'b0;
      DE_pc    <= '0;
      DE_inst  <= '0;
      DE_rs1   <= '0;
      DE_rs2   <= '0;
      DE_rd    <= '0;
      DE_rd_we <= 1'b0;
      DE_imm   <= '0;
      DE_op    <= CLS_NONE;
    end else if (issue) begin
      DE_valid <= 1'b1;
      DE_pc    <= FD_pc;
      DE_inst  <= FD_inst;
      DE_rs1   <= rs1;
      DE_rs2   <= rs2;
      DE_rd    <= rd;
      DE_rd_we <= writes_rd;
      DE_imm   <= imm;
      DE_op    <= cls;
    end else begin
      DE_valid <= 1'b0;
      DE_pc    <= '0;
      DE_inst  <= '0;
      DE_rs1   <= '0;
      DE_rs2   <= '0;
      DE_rd    <= '0;
      DE_rd_we <= 1'b0;
      DE_imm   <= '0;
      DE_op    <= CLS_NONE;
    end
  end

endmodule
